bcd_counter_ndigit: RTL and testbench

BCD_COUNTER_NDIGIT -- requirements
Module: bcd_counter_ndigit

---
 rtl/bcd_counter_ndigit.sv | 95 +++++++++
 tb/tb_bcd_counter_ndigit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/bcd_counter_ndigit.sv
// N-digit BCD up/down counter with synchronous load, terminal-count pulse and load error flag.
// Define BCD_COUNTER_SAT_EN to saturate at all-9s / all-0s instead of wrapping.
module bcd_counter_ndigit #(
  parameter int unsigned              DIGITS  = 4,
  parameter logic [4*DIGITS-1:0]      RST_VAL = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic                  load_err
);

  logic [4*DIGITS-1:0] count_q, count_d;
  logic                tc_q, tc_d;
  logic                load_err_q, load_err_d;

  logic [4*DIGITS-1:0] load_clean;
  logic                load_bad;
  logic [4*DIGITS-1:0] stepped;
  logic                carry;

  always_comb begin
    load_clean = '0;
    load_bad   = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) load_bad = 1'b1;
      else                           load_clean[4*i +: 4] = load_val[4*i +: 4];
    end
  end

  // Ripple carry/borrow through the digits; carry out of the top digit marks a wrap.
  always_comb begin
    stepped = count_q;
    carry   = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (up_dn) begin
          if (count_q[4*i +: 4] == 4'd9) begin
            stepped[4*i +: 4] = 4'd0;
          end else begin
            stepped[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (count_q[4*i +: 4] == 4'd0) begin
            stepped[4*i +: 4] = 4'd9;
          end else begin
            stepped[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    count_d    = count_q;
    tc_d       = 1'b0;
    load_err_d = load_err_q;
    if (load) begin
      count_d    = load_clean;
      load_err_d = load_bad;
    end else if (en) begin
`ifdef BCD_COUNTER_SAT_EN
      if (carry) tc_d = 1'b1;
      else       count_d = stepped;
`else
      count_d = stepped;
      tc_d    = carry;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q    <= RST_VAL;
      tc_q       <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      tc_q       <= tc_d;
      load_err_q <= load_err_d;
    end
  end

  assign count    = count_q;
  assign tc       = tc_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_counter_ndigit.sv
// Scoreboard bench for bcd_counter_ndigit: integer-arithmetic reference model feeds a queue,
// a monitor compares DUT outputs after every clock edge.
module tb_bcd_counter_ndigit;

  logic        clk;
  logic        reset;
  logic        en;
  logic        up_dn;
  logic        load;
  logic [15:0] load_val;
  logic [15:0] count;
  logic        tc;
  logic        load_err;

  bcd_counter_ndigit #(.DIGITS(4), .RST_VAL(16'h0000)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .tc       (tc),
    .load_err (load_err)
  );

  typedef struct packed {
    logic [15:0] c;
    logic        t;
    logic        e;
  } exp_t;

  exp_t        q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned m      = 0;
  bit          merr   = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] int2bcd(input int unsigned v);
    logic [15:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Model works on the plain integer value 0..9999.
  task automatic step(input bit ld, input logic [15:0] lv, input bit e, input bit u);
    bit          mtc;
    int unsigned p;
    @(negedge clk);
    load = ld; load_val = lv; en = e; up_dn = u;
    mtc = 1'b0;
    if (ld) begin
      m = 0; merr = 1'b0; p = 1;
      for (int i = 0; i < 4; i++) begin
        if (lv[4*i +: 4] > 4'd9) merr = 1'b1;
        else m = m + int'(lv[4*i +: 4]) * p;
        p = p * 10;
      end
    end else if (e) begin
      if (u) begin
        if (m == 9999) begin
          mtc = 1'b1;
`ifndef BCD_COUNTER_SAT_EN
          m = 0;
`endif
        end else m = m + 1;
      end else begin
        if (m == 0) begin
          mtc = 1'b1;
`ifndef BCD_COUNTER_SAT_EN
          m = 9999;
`endif
        end else m = m - 1;
      end
    end
    q.push_back('{c: int2bcd(m), t: mtc, e: merr});
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("count", 32'(count), 32'(x.c));
        chk("tc", 32'(tc), 32'(x.t));
        chk("load_err", 32'(load_err), 32'(x.e));
      end
    end
  end

  initial begin : driver
    logic [15:0] lv;
    logic [15:0] edge_vals [4];
    edge_vals[0] = 16'h9998; edge_vals[1] = 16'h9999;
    edge_vals[2] = 16'h0000; edge_vals[3] = 16'h0001;

    reset = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0;
    #50;
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_tc", 32'(tc), 32'h0);
    chk("rst_err", 32'(load_err), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Count up 12 from reset value: digit 0 wraps, digit 1 increments.
    repeat (12) step(1'b0, 16'h0, 1'b1, 1'b1);
    @(posedge clk);
    #2;
    chk("up12", 32'(count), 32'h0012);

    step(1'b1, 16'h9998, 1'b0, 1'b1);
    repeat (3) step(1'b0, 16'h0, 1'b1, 1'b1);
    step(1'b1, 16'h1000, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    step(1'b1, 16'h12A4, 1'b0, 1'b1);
    step(1'b0, 16'h0, 1'b0, 1'b1);
    step(1'b1, 16'h5555, 1'b1, 1'b1);
    step(1'b1, 16'h0000, 1'b1, 1'b0);
    repeat (3) step(1'b0, 16'h0, 1'b1, 1'b0);
    step(1'b1, 16'h0001, 1'b0, 1'b0);
    repeat (2) step(1'b0, 16'h0, 1'b1, 1'b0);
    repeat (2) step(1'b0, 16'h0, 1'b1, 1'b1);

    // Asynchronous reset between edges with count at 0x0457.
    step(1'b1, 16'h0457, 1'b0, 1'b1);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("async_rst_count", 32'(count), 32'h0);
    load = 1'b1; load_val = 16'h9999; en = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_over_load", 32'(count), 32'h0);
    chk("rst_over_tc", 32'(tc), 32'h0);
    m = 0; merr = 1'b0;
    @(negedge clk);
    reset = 1'b1; load = 1'b0; en = 1'b0;

    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 0) lv = edge_vals[$urandom_range(0, 3)];
        else                           lv = 16'($urandom);
        step(1'b1, lv, 1'($urandom), 1'($urandom));
      end else begin
        step(1'b0, 16'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom));
      end
    end

    repeat (2) @(posedge clk);
    #2;
    if (q.size() != 0) chk("scoreboard_drain", 32'(q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
